// File: rtl/jk_usr_pkg.sv
// Shared MODE encodings and controller state type for the JK universal shift register.
package jk_usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROTR = 3'b100;
    localparam logic [2:0] MODE_ROTL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/usr_step.sv
// Single combinational step of the universal shift register; shared by idle
// single-step and burst execution so both paths apply identical semantics.
module usr_step
    import jk_usr_pkg::*;
#(
    parameter int LENGTH = 4
) (
    input  logic [LENGTH-1:0] q_i,
    input  logic [2:0]        mode_i,
    input  logic              j_i,
    input  logic              k_i,
    input  logic              dsl_i,
    input  logic [LENGTH-1:0] p_i,
    output logic [LENGTH-1:0] q_nxt_o
);

    logic jk_bit;

    // K is active-low: J=0,K=1 holds, J=1,K=0 toggles.
    always_comb begin
        jk_bit = q_i[0];
        unique case ({j_i, k_i})
            2'b00: jk_bit = 1'b0;
            2'b11: jk_bit = 1'b1;
            2'b10: jk_bit = ~q_i[0];
            2'b01: jk_bit = q_i[0];
            default: jk_bit = q_i[0];
        endcase
    end

    always_comb begin
        q_nxt_o = q_i;
        case (mode_i)
            MODE_HOLD: q_nxt_o = q_i;
            MODE_SHR:  q_nxt_o = {q_i[LENGTH-2:0], jk_bit};
            MODE_SHL:  q_nxt_o = {dsl_i, q_i[LENGTH-1:1]};
            MODE_LOAD: q_nxt_o = p_i;
            MODE_ROTR: q_nxt_o = {q_i[LENGTH-2:0], q_i[LENGTH-1]};
            MODE_ROTL: q_nxt_o = {q_i[0], q_i[LENGTH-1:1]};
            default:   q_nxt_o = q_i;
        endcase
    end

endmodule

// File: rtl/jk_univ_shift_reg.sv
// Universal shift register with JK first stage, idle single-step and counted bursts.
// All outputs come straight from registered state; burst ignores MODE/EN/START/CNT.
module jk_univ_shift_reg
    import jk_usr_pkg::*;
#(
    parameter int LENGTH = 4,
    parameter int CNTW   = 5
) (
    input  logic              CP,
    input  logic              MR,
    input  logic [2:0]        MODE,
    input  logic              EN,
    input  logic              J,
    input  logic              K,
    input  logic              DSL,
    input  logic [LENGTH-1:0] P,
    input  logic              START,
    input  logic [CNTW-1:0]   CNT,
    output logic [LENGTH-1:0] Q,
    output logic              QNOT_MSB,
    output logic              BUSY,
    output logic              DONE
);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q,   cnt_d;
    logic [2:0]        mode_q,  mode_d;
    logic [LENGTH-1:0] q_q,     q_d;

    logic [2:0]        step_mode;
    logic [LENGTH-1:0] step_q;

    // During a burst the latched mode drives the step; otherwise the live MODE.
    assign step_mode = (state_q == ST_RUN) ? mode_q : MODE;

    usr_step #(
        .LENGTH (LENGTH)
    ) u_step (
        .q_i     (q_q),
        .mode_i  (step_mode),
        .j_i     (J),
        .k_i     (K),
        .dsl_i   (DSL),
        .p_i     (P),
        .q_nxt_o (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    mode_d  = MODE;
                    cnt_d   = CNT;
                    state_d = (CNT != '0) ? ST_RUN : ST_FIN;
                end else if (EN) begin
                    q_d = step_q;
                end
            end
            ST_RUN: begin
                q_d   = step_q;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
        end
    end

    assign Q        = q_q;
    assign QNOT_MSB = ~q_q[LENGTH-1];
    assign BUSY     = (state_q == ST_RUN) || (state_q == ST_FIN);
    assign DONE     = (state_q == ST_FIN);

endmodule

// File: tb/tb_jk_univ_shift_reg.sv
// Directed bench for jk_univ_shift_reg at LENGTH=4 and LENGTH=8 with a per-cycle reference model.
module tb_jk_univ_shift_reg;

    logic       CP = 1'b0;
    logic       MR;
    logic [2:0] MODE;
    logic       EN, J, K, DSL, START;
    logic [4:0] CNT;
    logic [3:0] P4, Q4;
    logic [7:0] P8, Q8;
    logic       qn4, busy4, done4, qn8, busy8, done8;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    jk_univ_shift_reg #(.LENGTH(4), .CNTW(5)) dut4 (
        .CP(CP), .MR(MR), .MODE(MODE), .EN(EN), .J(J), .K(K), .DSL(DSL),
        .P(P4), .START(START), .CNT(CNT),
        .Q(Q4), .QNOT_MSB(qn4), .BUSY(busy4), .DONE(done4)
    );

    jk_univ_shift_reg #(.LENGTH(8), .CNTW(5)) dut8 (
        .CP(CP), .MR(MR), .MODE(MODE), .EN(EN), .J(J), .K(K), .DSL(DSL),
        .P(P8), .START(START), .CNT(CNT),
        .Q(Q8), .QNOT_MSB(qn8), .BUSY(busy8), .DONE(done8)
    );

    always #5 CP = ~CP;

    // Model: register value as an integer, phase 0=idle 1=burst 2=finished.
    logic [31:0] m_q    [2] = '{32'd0, 32'd0};
    int          m_ph   [2] = '{0, 0};
    int          m_rem  [2] = '{0, 0};
    logic [2:0]  m_mode [2] = '{3'd0, 3'd0};

    function automatic int len_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] q, input logic [2:0] m,
                                           input logic j, input logic k, input logic d,
                                           input logic [31:0] p, input int n);
        logic [31:0] mask, top, low, msb, b;
        mask = (32'd1 << n) - 32'd1;
        msb  = (q >> (n - 1)) & 32'd1;
        low  = q & 32'd1;
        top  = 32'd1 << (n - 1);
        case (m)
            3'd1: begin
                if (!j && !k)     b = 32'd0;
                else if (j && k)  b = 32'd1;
                else if (j)       b = low ^ 32'd1;
                else              b = low;
                return ((q << 1) | b) & mask;
            end
            3'd2: return (q >> 1) | (d ? top : 32'd0);
            3'd3: return p & mask;
            3'd4: return ((q << 1) | msb) & mask;
            3'd5: return (q >> 1) | (low != 0 ? top : 32'd0);
            default: return q;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 32'd0; m_ph[i] = 0; m_rem[i] = 0; m_mode[i] = 3'd0;
        end
    endtask

    always @(negedge MR) m_reset();

    always @(posedge CP) begin
        if (!MR) begin
            m_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] p;
                p = (i == 0) ? {28'd0, P4} : {24'd0, P8};
                if (m_ph[i] == 0) begin
                    if (START) begin
                        m_mode[i] = MODE;
                        m_rem[i]  = int'(CNT);
                        m_ph[i]   = (CNT != 0) ? 1 : 2;
                    end else if (EN) begin
                        m_q[i] = m_step(m_q[i], MODE, J, K, DSL, p, len_of(i));
                    end
                end else if (m_ph[i] == 1) begin
                    m_q[i]   = m_step(m_q[i], m_mode[i], J, K, DSL, p, len_of(i));
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) m_ph[i] = 2;
                end else begin
                    m_ph[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CP) begin
        if (chk_en) begin
            chk("q4",     {28'd0, Q4},  m_q[0]);
            chk("qnot4",  {31'd0, qn4}, {31'd0, ~m_q[0][3]});
            chk("busy4",  {31'd0, busy4}, (m_ph[0] != 0) ? 32'd1 : 32'd0);
            chk("done4",  {31'd0, done4}, (m_ph[0] == 2) ? 32'd1 : 32'd0);
            chk("q8",     {24'd0, Q8},  m_q[1]);
            chk("qnot8",  {31'd0, qn8}, {31'd0, ~m_q[1][7]});
            chk("busy8",  {31'd0, busy8}, (m_ph[1] != 0) ? 32'd1 : 32'd0);
            chk("done8",  {31'd0, done8}, (m_ph[1] == 2) ? 32'd1 : 32'd0);
        end
    end

    task automatic cyc();
        @(posedge CP);
        #2;
    endtask

    task automatic load(input logic [3:0] v4, input logic [7:0] v8);
        MODE = 3'b011; EN = 1'b1; P4 = v4; P8 = v8;
        cyc();
        EN = 1'b0;
    endtask

    initial begin
        MR = 1'b0; MODE = 3'd0; EN = 1'b0; J = 1'b0; K = 1'b0; DSL = 1'b0;
        START = 1'b0; CNT = 5'd0; P4 = 4'd0; P8 = 8'd0;
        #1;
        chk("rst_q",    {28'd0, Q4}, 32'h0);
        chk("rst_qnot", {31'd0, qn4}, 32'h1);
        chk("rst_busy", {31'd0, busy4}, 32'h0);
        chk("rst_done", {31'd0, done4}, 32'h0);
        chk_en = 1'b1;
        cyc(); cyc();
        MR = 1'b1;

        // Load then JK shift right with toggle
        load(4'b1011, 8'hA5);
        chk("ld_1011", {28'd0, Q4}, 32'hB);
        MODE = 3'b001; J = 1'b1; K = 1'b0; EN = 1'b1;
        cyc();
        EN = 1'b0;
        chk("shr_0110", {28'd0, Q4}, 32'h6);

        // Asynchronous clear between edges
        load(4'b1010, 8'h5A);
        chk("ld_1010", {28'd0, Q4}, 32'hA);
        #1 MR = 1'b0;
        #1;
        chk("async_q",    {28'd0, Q4}, 32'h0);
        chk("async_qnot", {31'd0, qn4}, 32'h1);
        cyc();
        MR = 1'b1;

        // First edge after release is a normal idle edge; burst rotate right x3
        load(4'b0001, 8'h01);
        chk("ld_0001", {28'd0, Q4}, 32'h1);
        MODE = 3'b100; CNT = 5'd3; START = 1'b1;
        cyc();
        START = 1'b0; MODE = 3'b000; CNT = 5'd0;
        chk("b_launch_q", {28'd0, Q4}, 32'h1);
        chk("b_launch_busy", {31'd0, busy4}, 32'h1);
        cyc();
        chk("b_s1", {28'd0, Q4}, 32'h2);
        cyc();
        chk("b_s2", {28'd0, Q4}, 32'h4);
        cyc();
        chk("b_s3", {28'd0, Q4}, 32'h8);
        chk("b_done", {31'd0, done4}, 32'h1);
        chk("b_busy", {31'd0, busy4}, 32'h1);
        START = 1'b1;
        cyc();
        START = 1'b0;
        chk("b_after_busy", {31'd0, busy4}, 32'h0);
        chk("b_after_done", {31'd0, done4}, 32'h0);

        // Zero-count burst with EN asserted alongside START
        MODE = 3'b100; CNT = 5'd0; START = 1'b1; EN = 1'b1;
        cyc();
        START = 1'b0; EN = 1'b0;
        chk("z_q", {28'd0, Q4}, 32'h8);
        chk("z_done", {31'd0, done4}, 32'h1);
        cyc();
        chk("z_done_off", {31'd0, done4}, 32'h0);

        // Shift-left burst aborted by reset; MODE/EN changes during burst ignored
        load(4'b1001, 8'h81);
        MODE = 3'b010; CNT = 5'd5; START = 1'b1; DSL = 1'b0;
        cyc();
        START = 1'b0; MODE = 3'b011; EN = 1'b1; P4 = 4'b1111; MODE = 3'b101;
        cyc();
        chk("a_s1", {28'd0, Q4}, 32'h4);
        DSL = 1'b1;
        cyc();
        chk("a_s2", {28'd0, Q4}, 32'hA);
        #1 MR = 1'b0;
        #1;
        chk("a_q", {28'd0, Q4}, 32'h0);
        chk("a_busy", {31'd0, busy4}, 32'h0);
        MODE = 3'b000; EN = 1'b0;
        cyc();
        MR = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cyc();
            chk("a_no_done", {31'd0, done4}, 32'h0);
        end

        // JK table on the 8-bit instance
        load(4'b0000, 8'h00);
        MODE = 3'b001; EN = 1'b1;
        J = 1'b1; K = 1'b1; cyc(); chk("jk_11", {24'd0, Q8}, 32'h01);
        J = 1'b1; K = 1'b0; cyc(); chk("jk_10a", {24'd0, Q8}, 32'h02);
        J = 1'b1; K = 1'b0; cyc(); chk("jk_10b", {24'd0, Q8}, 32'h05);
        J = 1'b0; K = 1'b1; cyc(); chk("jk_01", {24'd0, Q8}, 32'h0B);
        J = 1'b0; K = 1'b0; cyc(); chk("jk_00", {24'd0, Q8}, 32'h16);
        J = 1'b1; K = 1'b1; cyc(); chk("jk_11b", {24'd0, Q8}, 32'h2D);
        EN = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
